apb_slave_responder: RTL and testbench
======================================

Name: apb_slave_responder

Overview:
- Synthesizable APB completer (slave responder): the responding end of the APB link that the slave-side monitors observe.
- Decodes setup/access phases and inserts a programmable number of wait states.
- Backs a byte-strobed register file and flags protocol violations.
- Sits in hdl_top as the DUT-side completer, or as a reusable RTL slave model behind the master driver.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32.
- NUM_REGS, 16, number of DATA_WIDTH-bit registers.
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- MAX_WAIT, 15, maximum wait states; sets wait_cycles width WW = $clog2(MAX_WAIT+1).

Ports:
- pclk  input  1  APB clock; all state on rising edge.
- preset_n  input  1  asynchronous active-low reset.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- pprot  input  3  protection; accepted, not checked.
- wait_cycles  input  WW  wait states per transfer; sampled in the setup cycle.
- pready  output  1  transfer-complete.
- prdata  output  DATA_WIDTH  read data.
- pslverr  output  1  transfer error, valid with pready.
- protocol_err  output  1  one-cycle pulse on a bus-protocol violation.

Behaviour:
- Reset: preset_n low asynchronously forces state=IDLE, wait counter=0, all registers=0, protocol_err=0. pready, prdata and pslverr are 0 while in IDLE.
- FSM states are IDLE and ACCESS. The setup cycle is spent in IDLE.
- IDLE, psel=1 and penable=0: at the edge, latch pwrite/paddr/pwdata/pstrb, load cnt=min(wait_cycles, MAX_WAIT), go to ACCESS.
- IDLE, psel=1 and penable=1: no setup was seen. Stay in IDLE, pulse protocol_err next cycle, write nothing.
- ACCESS, psel=1 and penable=1 and cnt>0: cnt decrements, pready=0.
- ACCESS, psel=1 and penable=1 and cnt=0: pready=1 (combinational from state/cnt). The transfer commits at this edge and the FSM returns to IDLE.
  - With wait_cycles=0, a transfer takes 2 cycles (setup plus one access).
  - With wait_cycles=N, it takes N+2 cycles.
- ACCESS, psel=0 or penable=0: abort. Go to IDLE, no write, pulse protocol_err.
  - Exception: psel=1 with penable=0 is also treated as a fresh setup, so the FSM relatches and goes back to ACCESS after the pulse.
- Values latched at setup are used for the whole transfer. paddr/pwdata changes during ACCESS are ignored.
- Decode: idx = (addr - BASE_ADDR) / (DATA_WIDTH/8).
  - Error when addr < BASE_ADDR, idx >= NUM_REGS, or addr is not aligned to DATA_WIDTH/8.
  - On error: pslverr=1 in the pready cycle, no register written, prdata=0.
- Write commit: for each byte b with pstrb[b]=1, reg[idx][8b+7:8b] = pwdata byte. pstrb=0 is a legal no-op write.
- Read: prdata = reg[idx] only in the pready cycle; 0 otherwise. A read never changes state.
- Back-to-back: the cycle after completion is an IDLE/setup cycle. If psel stays 1 with penable=0, the next transfer starts with no idle gap.
- A reset asserted mid-transfer abandons it. Any write not yet committed is lost, and outputs drop to 0 immediately.
- Simultaneous commit and reset: reset wins.

Decomposition:
- apb_global_pkg holds:
  - the state enum (IDLE, ACCESS);
  - a transfer struct {write, addr, wdata, strb};
  - the constant STRB_WIDTH = DATA_WIDTH/8.
- One natural sub-module, apb_slave_regfile:
  - NUM_REGS x DATA_WIDTH storage;
  - inputs: byte-strobe write port (we, idx, wdata, strb) and combinational read port (idx -> rdata);
  - contains no protocol logic.

Test Plan:
- Write then read, wait_cycles=0: write paddr=0x4, pwdata=0xDEADBEEF, pstrb=4'hF, then read 0x4 -> pready high in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- Partial strobe, wait_cycles=3: reg 0x8 preloaded with 0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> pready high 5 cycles after setup start; readback 0x11BB33DD.
- Address errors: write 0x40 (NUM_REGS=16) and read 0x6 -> pslverr=1 with pready, prdata=0; a full register dump is unchanged.
- Protocol violations:
  - penable=1 with no setup -> protocol_err pulses 1 cycle, no pready.
  - psel dropped in ACCESS with wait_cycles=2 -> abort, protocol_err pulse, target register unchanged.
- Back-to-back: three writes (0x0, 0x4, 0xC) with psel held high and wait_cycles=1 -> 9 cycles total, all three registers correct.
- Reset mid-transfer: preset_n low during the 2nd wait cycle of a write to 0x4 -> pready/prdata/pslverr become 0 asynchronously; after release, reg 0x4 reads 0.

Source files
------------

// File: rtl/apb_global_pkg.sv
// ---------------------------------------------------------------------------
// apb_global_pkg
// Shared types and constants for the APB completer:
//   - apb_state_e : FSM states (IDLE holds the setup cycle, ACCESS the rest)
//   - apb_xfer_t  : transfer captured in the setup cycle
//   - STRB_WIDTH  : byte lanes of the widest supported data bus
//   - strb_merge  : byte-strobed merge of a new word into an old word
// Struct fields are sized for the widest configuration (32-bit address and
// data); narrower instances use the low bits only.
// ---------------------------------------------------------------------------
package apb_global_pkg;

  localparam int PKG_ADDR_WIDTH = 32;
  localparam int PKG_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = PKG_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     strb;
  } apb_xfer_t;

  // Replace each byte of old_word whose strobe bit is set.
  function automatic logic [PKG_DATA_WIDTH-1:0] strb_merge(
    input logic [PKG_DATA_WIDTH-1:0] old_word,
    input logic [PKG_DATA_WIDTH-1:0] new_word,
    input logic [STRB_WIDTH-1:0]     strb
  );
    logic [PKG_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// NUM_REGS x DATA_WIDTH register storage with a byte-strobed write port and
// a combinational read port. No bus protocol knowledge lives here.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all)
//   we, wr_idx, wdata,  write enable, register index, data, byte strobes
//   strb
//   rd_idx -> rdata     combinational read (0 for an out-of-range index)
// ---------------------------------------------------------------------------
module apb_slave_regfile
  import apb_global_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IW         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IW-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [IW-1:0]           rd_idx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];
  logic [PKG_DATA_WIDTH-1:0] merged_s;
  logic                      wr_ok_s;
  logic                      rd_ok_s;

  assign wr_ok_s = ({1'b0, wr_idx} < (IW+1)'(NUM_REGS));
  assign rd_ok_s = ({1'b0, rd_idx} < (IW+1)'(NUM_REGS));

  // Next-state of the storage: merge strobed bytes into the addressed word.
  always_comb begin
    regs_d   = regs_q;
    merged_s = strb_merge(PKG_DATA_WIDTH'(regs_q[wr_idx]),
                          PKG_DATA_WIDTH'(wdata),
                          STRB_WIDTH'(strb));
    if (we && wr_ok_s) begin
      regs_d[wr_idx] = merged_s[DATA_WIDTH-1:0];
    end else begin
      regs_d[wr_idx] = regs_q[wr_idx];
    end
  end

  // Storage flops, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read port.
  always_comb begin
    if (rd_ok_s) begin
      rdata = regs_q[rd_idx];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/apb_slave_responder.sv
// ---------------------------------------------------------------------------
// apb_slave_responder
// APB completer backed by a byte-strobed register file. Captures the
// transfer in the setup cycle, inserts a programmable number of wait states,
// decodes the address against BASE_ADDR and flags protocol violations.
// Ports:
//   pclk, preset_n      clock, asynchronous active-low reset
//   psel, penable,      APB request signals (pprot accepted, not checked)
//   pwrite, paddr,
//   pwdata, pstrb, pprot
//   wait_cycles         wait states for the transfer, sampled at setup
//   pready              transfer complete (combinational from state/count)
//   prdata              read data, nonzero only in a good read's pready cycle
//   pslverr             decode error, valid with pready
//   protocol_err        one-cycle pulse after a bus-protocol violation
// ADDR_WIDTH and DATA_WIDTH may not exceed 32; MAX_WAIT must be >= 1.
// ---------------------------------------------------------------------------
module apb_slave_responder
  import apb_global_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WAIT   = 15
) (
  input  logic                            pclk,
  input  logic                            preset_n,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [ADDR_WIDTH-1:0]           paddr,
  input  logic [DATA_WIDTH-1:0]           pwdata,
  input  logic [DATA_WIDTH/8-1:0]         pstrb,
  input  logic [2:0]                      pprot,
  input  logic [$clog2(MAX_WAIT+1)-1:0]   wait_cycles,
  output logic                            pready,
  output logic [DATA_WIDTH-1:0]           prdata,
  output logic                            pslverr,
  output logic                            protocol_err
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e          state_q, state_d;
  logic [WW-1:0]       cnt_q, cnt_d;
  apb_xfer_t           xfer_q, xfer_d;
  logic                perr_q, perr_d;

  apb_xfer_t           setup_xfer_s;
  logic [WW-1:0]       wait_lim_s;
  logic                we_s;
  logic                pready_s;

  logic [ADDR_WIDTH-1:0] addr_s;
  logic [ADDR_WIDTH-1:0] base_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [ADDR_WIDTH-1:0] idx_full_s;
  logic [IW-1:0]         idx_s;
  logic                  dec_err_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

  // Snapshot of the bus for a setup cycle, and the clamped wait count.
  always_comb begin
    setup_xfer_s       = '0;
    setup_xfer_s.write = pwrite;
    setup_xfer_s.addr  = PKG_ADDR_WIDTH'(paddr);
    setup_xfer_s.wdata = PKG_DATA_WIDTH'(pwdata);
    setup_xfer_s.strb  = STRB_WIDTH'(pstrb);
    if (wait_cycles > WW'(MAX_WAIT)) begin
      wait_lim_s = WW'(MAX_WAIT);
    end else begin
      wait_lim_s = wait_cycles;
    end
  end

  // Address decode on the latched address; the offset is only meaningful
  // when the address is not below BASE_ADDR.
  assign addr_s     = xfer_q.addr[ADDR_WIDTH-1:0];
  assign base_s     = BASE_ADDR[ADDR_WIDTH-1:0];
  assign off_s      = addr_s - base_s;
  assign idx_full_s = off_s / ADDR_WIDTH'(SW);
  assign idx_s      = idx_full_s[IW-1:0];
  assign dec_err_s  = (addr_s < base_s)
                    || ((off_s % ADDR_WIDTH'(SW)) != '0)
                    || (idx_full_s >= ADDR_WIDTH'(NUM_REGS));

  assign unused_s = ^{pprot, idx_full_s[ADDR_WIDTH-1:IW]};

  // Next-state, wait counter, capture and commit decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    perr_d  = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          xfer_d  = setup_xfer_s;
          cnt_d   = wait_lim_s;
          state_d = ACCESS;
        end else if (psel && penable) begin
          // Access phase without a preceding setup: flag it, do nothing.
          perr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (psel && penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WW'(1'b1);
          end else begin
            we_s    = xfer_q.write && !dec_err_s;
            state_d = IDLE;
          end
        end else begin
          perr_d = 1'b1;
          if (psel) begin
            // psel without penable doubles as a fresh setup.
            xfer_d  = setup_xfer_s;
            cnt_d   = wait_lim_s;
            state_d = ACCESS;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, captured transfer and error-pulse registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xfer_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      perr_q  <= perr_d;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IW         (IW)
  ) u_regfile (
    .clk    (pclk),
    .rst_n  (preset_n),
    .we     (we_s),
    .wr_idx (idx_s),
    .wdata  (xfer_q.wdata[DATA_WIDTH-1:0]),
    .strb   (xfer_q.strb[SW-1:0]),
    .rd_idx (idx_s),
    .rdata  (rdata_s)
  );

  // pready depends only on state and count, so reset clears it at once.
  assign pready_s     = (state_q == ACCESS) && (cnt_q == '0);
  assign pready       = pready_s;
  assign pslverr      = pready_s && dec_err_s;
  assign prdata       = (pready_s && !xfer_q.write && !dec_err_s) ? rdata_s : '0;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
module tb_apb_slave_responder;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  wait_cycles;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        protocol_err;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_regs [16];

  apb_slave_responder dut (
    .pclk         (clk),
    .preset_n     (rst_n),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .pprot        (pprot),
    .wait_cycles  (wait_cycles),
    .pready       (pready),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transfer. Setup is driven on a negedge; paddr/pwdata are
  // scrambled during ACCESS. Returns with psel/penable still high.
  task automatic apb_xfer(input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] ws, output logic [31:0] rd,
                          output logic err, output int cyc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr;
    pwdata = data; pstrb = strb; wait_cycles = ws; cyc = 1;
    @(negedge clk);
    penable = 1'b1; paddr = ~addr; pwdata = ~data; cyc = 2;
    #1;
    while (!pready && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    n_vec++;
    if (pready !== 1'b1) begin
      $display("FAIL xfer_timeout: addr=%h pready=%b required 1", addr, pready);
      n_err++;
    end
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic apb_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
    wait_cycles = 4'd0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    #12;
    n_vec++; if (pready !== 1'b0) begin $display("FAIL rst_pready: got %b want 0", pready); n_err++; end
    n_vec++; if (prdata !== 32'h0) begin $display("FAIL rst_prdata: got %h want 0", prdata); n_err++; end
    n_vec++; if (pslverr !== 1'b0) begin $display("FAIL rst_pslverr: got %b want 0", pslverr); n_err++; end
    n_vec++; if (protocol_err !== 1'b0) begin $display("FAIL rst_perr: got %b want 0", protocol_err); n_err++; end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (pready !== 1'b0) begin $display("FAIL post_rst_pready: got %b want 0", pready); n_err++; end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 4'd0, rd, err, cyc);
    exp_regs[1] = 32'hDEADBEEF;
    n_vec++; if (cyc !== 2) begin $display("FAIL wr_cycles: got %0d want 2", cyc); n_err++; end
    n_vec++; if (err !== 1'b0) begin $display("FAIL wr_slverr: got %b want 0", err); n_err++; end
    apb_idle(); #1;
    n_vec++; if (pready !== 1'b0) begin $display("FAIL idle_pready: got %b want 0", pready); n_err++; end
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (cyc !== 2) begin $display("FAIL rd_cycles: got %0d want 2", cyc); n_err++; end
    n_vec++; if (rd !== 32'hDEADBEEF) begin $display("FAIL rd_data: got %h want DEADBEEF", rd); n_err++; end
    n_vec++; if (err !== 1'b0) begin $display("FAIL rd_slverr: got %b want 0", err); n_err++; end
    apb_idle();
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'h8, 32'h11223344, 4'hF, 4'd0, rd, err, cyc);
    apb_idle();
    apb_xfer(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 4'd3, rd, err, cyc);
    exp_regs[2] = 32'h11BB33DD;
    n_vec++; if (cyc !== 5) begin $display("FAIL strb_cycles: got %0d want 5", cyc); n_err++; end
    n_vec++; if (err !== 1'b0) begin $display("FAIL strb_slverr: got %b want 0", err); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h11BB33DD) begin $display("FAIL strb_rd: got %h want 11BB33DD", rd); n_err++; end
    apb_idle();
    apb_xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (err !== 1'b0) begin $display("FAIL nostrb_slverr: got %b want 0", err); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h11BB33DD) begin $display("FAIL nostrb_rd: got %h want 11BB33DD", rd); n_err++; end
    apb_idle();
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'h40, 32'h01234567, 4'hF, 4'd0, rd, err, cyc);
    n_vec++; if (err !== 1'b1) begin $display("FAIL oor_wr_slverr: got %b want 1", err); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h6, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (err !== 1'b1) begin $display("FAIL misalign_slverr: got %b want 1", err); n_err++; end
    n_vec++; if (rd !== 32'h0) begin $display("FAIL misalign_prdata: got %h want 0", rd); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h3C, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (err !== 1'b0) begin $display("FAIL last_reg_slverr: got %b want 0", err); n_err++; end
    apb_idle();
    for (int i = 0; i < 16; i++) begin
      apb_xfer(1'b0, 32'(4 * i), 32'h0, 4'h0, 4'd0, rd, err, cyc);
      n_vec++;
      if (rd !== exp_regs[i]) begin
        $display("FAIL dump_reg%0d: got %h want %h", i, rd, exp_regs[i]); n_err++;
      end
      apb_idle();
    end
  endtask

  task automatic test_protocol();
    logic [31:0] rd; logic err; int cyc;
    // Access phase with no setup.
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; wait_cycles = 4'd0;
    @(negedge clk);
    n_vec++; if (protocol_err !== 1'b1) begin $display("FAIL nosetup_perr: got %b want 1", protocol_err); n_err++; end
    n_vec++; if (pready !== 1'b0) begin $display("FAIL nosetup_pready: got %b want 0", pready); n_err++; end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_vec++; if (protocol_err !== 1'b0) begin $display("FAIL nosetup_pulse: got %b want 0", protocol_err); n_err++; end
    // psel dropped during the wait states.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
    pwdata = 32'h55AA55AA; pstrb = 4'hF; wait_cycles = 4'd2;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_vec++; if (protocol_err !== 1'b1) begin $display("FAIL abort_perr: got %b want 1", protocol_err); n_err++; end
    n_vec++; if (pready !== 1'b0) begin $display("FAIL abort_pready: got %b want 0", pready); n_err++; end
    @(negedge clk);
    n_vec++; if (protocol_err !== 1'b0) begin $display("FAIL abort_pulse: got %b want 0", protocol_err); n_err++; end
    // penable dropped in ACCESS: restarts as a new setup.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h0BADF00D; pstrb = 4'hF; wait_cycles = 4'd2;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0; paddr = 32'h14; pwdata = 32'h600DCAFE; wait_cycles = 4'd0;
    @(negedge clk);
    n_vec++; if (protocol_err !== 1'b1) begin $display("FAIL resetup_perr: got %b want 1", protocol_err); n_err++; end
    penable = 1'b1; #1;
    n_vec++; if (pready !== 1'b1) begin $display("FAIL resetup_pready: got %b want 1", pready); n_err++; end
    exp_regs[5] = 32'h600DCAFE;
    apb_idle();
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== exp_regs[3]) begin $display("FAIL abort_reg: got %h want %h", rd, exp_regs[3]); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== exp_regs[0]) begin $display("FAIL nosetup_reg: got %h want %h", rd, exp_regs[0]); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h0) begin $display("FAIL resetup_old: got %h want 0", rd); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h600DCAFE) begin $display("FAIL resetup_new: got %h want 600DCAFE", rd); n_err++; end
    apb_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc; int total;
    total = 0;
    apb_xfer(1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 4'd1, rd, err, cyc); total += cyc;
    apb_xfer(1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, 4'd1, rd, err, cyc); total += cyc;
    apb_xfer(1'b1, 32'hC, 32'hC2C2C2C2, 4'hF, 4'd1, rd, err, cyc); total += cyc;
    exp_regs[0] = 32'hA0A0A0A0; exp_regs[1] = 32'hB1B1B1B1; exp_regs[3] = 32'hC2C2C2C2;
    n_vec++; if (total !== 9) begin $display("FAIL b2b_cycles: got %0d want 9", total); n_err++; end
    apb_idle();
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'hA0A0A0A0) begin $display("FAIL b2b_reg0: got %h want A0A0A0A0", rd); n_err++; end
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'hB1B1B1B1) begin $display("FAIL b2b_reg1: got %h want B1B1B1B1", rd); n_err++; end
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'hC2C2C2C2) begin $display("FAIL b2b_reg3: got %h want C2C2C2C2", rd); n_err++; end
    apb_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    // Reset in the second wait cycle of a write to 0x4.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4;
    pwdata = 32'h12345678; pstrb = 4'hF; wait_cycles = 4'd3;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); #2; rst_n = 1'b0; #1;
    n_vec++; if (pready !== 1'b0) begin $display("FAIL midrst_pready: got %b want 0", pready); n_err++; end
    n_vec++; if (prdata !== 32'h0) begin $display("FAIL midrst_prdata: got %h want 0", prdata); n_err++; end
    n_vec++; if (pslverr !== 1'b0) begin $display("FAIL midrst_pslverr: got %b want 0", pslverr); n_err++; end
    @(negedge clk); psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h0) begin $display("FAIL midrst_reg1: got %h want 0", rd); n_err++; end
    apb_idle();
    // Reset in a read's pready cycle drops outputs immediately.
    apb_xfer(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 4'd0, rd, err, cyc);
    apb_idle();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8; wait_cycles = 4'd0;
    @(negedge clk); penable = 1'b1; #1;
    n_vec++; if (prdata !== 32'hCAFEF00D) begin $display("FAIL prerst_prdata: got %h want CAFEF00D", prdata); n_err++; end
    #1; rst_n = 1'b0; #1;
    n_vec++; if (pready !== 1'b0) begin $display("FAIL asyncrst_pready: got %b want 0", pready); n_err++; end
    n_vec++; if (prdata !== 32'h0) begin $display("FAIL asyncrst_prdata: got %h want 0", prdata); n_err++; end
    @(negedge clk); psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    // Reset held across the commit edge of a write to 0xC.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
    pwdata = 32'hDDDDDDDD; pstrb = 4'hF; wait_cycles = 4'd0;
    @(negedge clk); penable = 1'b1; #4; rst_n = 1'b0;
    @(negedge clk); psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h0) begin $display("FAIL asyncrst_reg2: got %h want 0", rd); n_err++; end
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, rd, err, cyc);
    n_vec++; if (rd !== 32'h0) begin $display("FAIL commitrst_reg3: got %h want 0", rd); n_err++; end
    apb_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_addr_err();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
